// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int STEPS      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between a controller and seq_divider.
interface seq_divider_if;
  import div_pkg::*;

  // Start is a level request sampled only in IDLE; Done rises with valid
  // results and stays high until Start is dropped, then clears on that edge.
  logic                  Start;
  logic [DIVIDEND_W-1:0] Dividend;
  logic [DIVISOR_W-1:0]  Divisor;
  logic [DIVISOR_W-1:0]  Quotient;
  logic [DIVISOR_W-1:0]  Remainder;
  logic                  Overflow;
  logic                  DivZero;
  logic                  Done;
  state_t                dbg_state;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Overflow, DivZero, Done, dbg_state
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Overflow, DivZero, Done, dbg_state
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 in_bit,
  input  logic [DIVISOR_W-1:0] dvs,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);
  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] diff;

  // The partial remainder stays below |Divisor| <= 128, so 8 bits plus the new bit fit.
  assign shifted = {pr[DIVISOR_W-1:0], in_bit};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};

  always_comb begin
    q_bit   = ~diff[DIVISOR_W+1];
    pr_next = q_bit ? diff[DIVISOR_W:0] : shifted;
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider, 16-bit by 8-bit, Start/Done level handshake.
module seq_divider
  import div_pkg::*;
(
  input  logic          Clock,
  input  logic          Reset,
  seq_divider_if.slave  bus
);
  state_t                state;
  logic [3:0]            cnt;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic                  sign_q;
  logic                  sign_r;
  logic [DIVISOR_W:0]    pr;
  logic [DIVIDEND_W-1:0] q16;
  logic [DIVISOR_W-1:0]  quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  overflow;
  logic                  div_zero;
  logic                  done;

  logic [DIVISOR_W:0]    pr_next;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W-1:0]  dvs_abs;

  assign dvd_abs = bus.Dividend[DIVIDEND_W-1] ? DIVIDEND_W'(~bus.Dividend + 16'd1) : bus.Dividend;
  assign dvs_abs = bus.Divisor[DIVISOR_W-1]   ? DIVISOR_W'(~bus.Divisor + 8'd1)    : bus.Divisor;

  div_step u_step (
    .pr      (pr),
    .in_bit  (dvd_mag[DIVIDEND_W-1]),
    .dvs     (dvs_mag),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_mag   <= '0;
      dvs_mag   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      pr        <= '0;
      q16       <= '0;
      quotient  <= '0;
      remainder <= '0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (bus.Divisor == '0) begin
              quotient  <= '0;
              remainder <= bus.Dividend[DIVISOR_W-1:0];
              overflow  <= 1'b0;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              dvd_mag   <= dvd_abs;
              dvs_mag   <= dvs_abs;
              sign_q    <= bus.Dividend[DIVIDEND_W-1] ^ bus.Divisor[DIVISOR_W-1];
              sign_r    <= bus.Dividend[DIVIDEND_W-1];
              pr        <= '0;
              q16       <= '0;
              cnt       <= '0;
              quotient  <= '0;
              remainder <= '0;
              overflow  <= 1'b0;
              div_zero  <= 1'b0;
              done      <= 1'b0;
              state     <= WORK;
            end
          end
        end
        WORK: begin
          pr      <= pr_next;
          q16     <= {q16[DIVIDEND_W-2:0], q_bit};
          dvd_mag <= {dvd_mag[DIVIDEND_W-2:0], 1'b0};
          cnt     <= cnt + 4'd1;
          if (cnt == 4'(STEPS - 1)) state <= FIX;
        end
        FIX: begin
          // On overflow the low 8 bits of the signed quotient are still reported.
          quotient  <= sign_q ? DIVISOR_W'(~q16[DIVISOR_W-1:0] + 8'd1) : q16[DIVISOR_W-1:0];
          remainder <= sign_r ? DIVISOR_W'(~pr[DIVISOR_W-1:0] + 8'd1)  : pr[DIVISOR_W-1:0];
          overflow  <= (!sign_q && q16 > 16'd127) || (sign_q && q16 > 16'd128);
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (!bus.Start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Quotient  = quotient;
  assign bus.Remainder = remainder;
  assign bus.Overflow  = overflow;
  assign bus.DivZero   = div_zero;
  assign bus.Done      = done;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  import div_pkg::*;

  logic Clock;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic [17:0] exp_q[$];

  seq_divider_if bus ();

  seq_divider dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain signed integer division, truncation toward zero.
  function automatic logic [17:0] model(input logic [15:0] dvd, input logic [7:0] dvs);
    int a, b, q, r;
    logic ovf;
    if (dvs == 8'd0) return {1'b0, 1'b1, 8'd0, dvd[7:0]};
    a   = int'($signed(dvd));
    b   = int'($signed(dvs));
    q   = a / b;
    r   = a % b;
    ovf = (q > 127) || (q < -128);
    return {ovf, 1'b0, q[7:0], r[7:0]};
  endfunction

  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input bit perturb);
    logic [17:0] e;
    int lat;
    exp_q.push_back(model(dvd, dvs));
    @(negedge Clock);
    bus.Start    = 1'b1;
    bus.Dividend = dvd;
    bus.Divisor  = dvs;
    @(posedge Clock); #1;
    lat = 0;
    while (!bus.Done && lat < 40) begin
      if (perturb) begin
        @(negedge Clock);
        bus.Start    = 1'($urandom_range(0, 1));
        bus.Dividend = 16'($urandom);
        bus.Divisor  = 8'($urandom);
      end
      @(posedge Clock); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check("latency",   lat, (dvs == 8'd0) ? 0 : 17);
    check("done",      bus.Done, 1'b1);
    check("quotient",  bus.Quotient, e[15:8]);
    check("remainder", bus.Remainder, e[7:0]);
    check("overflow",  bus.Overflow, e[17]);
    check("divzero",   bus.DivZero, e[16]);
    // Holding Start must not retrigger.
    @(negedge Clock);
    bus.Start = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("hold_done",  bus.Done, 1'b1);
    check("hold_state", bus.dbg_state, DONE);
    check("hold_quot",  bus.Quotient, e[15:8]);
    @(negedge Clock);
    bus.Start = 1'b0;
    @(posedge Clock); #1;
    check("drop_done",  bus.Done, 1'b0);
    check("drop_state", bus.dbg_state, IDLE);
    check("drop_quot",  bus.Quotient, e[15:8]);
    check("drop_rem",   bus.Remainder, e[7:0]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quot"},  bus.Quotient, 8'd0);
    check({tag, "_rem"},   bus.Remainder, 8'd0);
    check({tag, "_ovf"},   bus.Overflow, 1'b0);
    check({tag, "_dz"},    bus.DivZero, 1'b0);
    check({tag, "_done"},  bus.Done, 1'b0);
    check({tag, "_state"}, bus.dbg_state, IDLE);
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  rv;
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_zero_outputs("reset");
    @(negedge Clock);
    Reset = 1'b0;

    // Directed cases: basic, sign matrix, range edges, divide by zero.
    run_op(16'd100,                8'd7,                 1'b0);
    run_op(16'($signed(-100)),     8'd7,                 1'b0);
    run_op(16'd100,                8'($signed(-7)),      1'b0);
    run_op(16'($signed(-100)),     8'($signed(-7)),      1'b0);
    run_op(16'($signed(-16384)),   8'h80,                1'b0);
    run_op(16'd16384,              8'h80,                1'b0);
    run_op(16'd1000,               8'd3,                 1'b0);
    run_op(16'h8000,               8'h80,                1'b0);
    run_op(16'd1234,               8'd0,                 1'b0);

    // Reset in the middle of WORK.
    @(negedge Clock);
    bus.Start    = 1'b1;
    bus.Dividend = 16'd100;
    bus.Divisor  = 8'd7;
    @(posedge Clock);
    repeat (6) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(negedge Clock);
    bus.Start = 1'b0;
    Reset     = 1'b0;
    run_op(16'd50, 8'd5, 1'b0);

    // Inputs and Start disturbed while the divide is running.
    run_op(16'd100, 8'd7, 1'b1);
    run_op(16'($signed(-3000)), 8'd41, 1'b1);

    // Random operands, including some zero divisors.
    for (int i = 0; i < 25; i++) begin
      rd = 16'($urandom);
      rv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(rd, rv, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
